hamming_secded_engine: RTL

Parametrised, pipelined Hamming SECDED codec that carries programs 1 and 2 (parity insertion, then single-error correction and double-error detection) from software into a hardware datapath. It accepts one word per cycle on a valid/ready stream and runs encode or decode per beat. It counts corrected and uncorrectable words. It sits beside the data memory as a co-processor on the same clock as `top_level`.

---
 rtl/hamming_secded_engine.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hamming_secded_engine.sv
`default_nettype none
// ============================================================================
// hamming_secded_engine
//   Two-stage pipelined Hamming SECDED encoder/decoder on a valid/ready stream
//   with saturating corrected / uncorrectable word counters.
// Revision: 1.0
// ============================================================================

module hamming_secded_engine #(
  parameter int K     = 11,
  parameter int R     = 4,
  parameter int N     = K + R + 1,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             start_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_dbl,
  input  logic             clr
);

  localparam logic [1:0] c_err_clean = 2'b00;
  localparam logic [1:0] c_err_corr  = 2'b01;
  localparam logic [1:0] c_err_dbl   = 2'b10;
  localparam logic [1:0] c_err_par   = 2'b11;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  generate
    if ((1 << R) < (K + R + 1)) begin : g_bad_r
      $error("hamming_secded_engine: R too small to protect K data bits");
    end
    if (N != K + R + 1) begin : g_bad_n
      $error("hamming_secded_engine: N must equal K+R+1");
    end
  endgenerate

  // Codeword position of data bit idx: the idx-th non-power-of-two position >= 3.
  function automatic int data_pos(input int idx);
    int cnt;
    data_pos = 0;
    cnt      = 0;
    for (int p = 1; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) data_pos = p;
        cnt++;
      end
    end
  endfunction

  logic             r_v1;
  logic             r_mode;
  logic [N-1:0]     r_word;
  logic             r_v2;
  logic [N-1:0]     r_data2;
  logic [1:0]       r_err2;
  logic [CNT_W-1:0] r_cnt_corr;
  logic [CNT_W-1:0] r_cnt_dbl;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_out_fire;
  logic [N-1:0]     w_enc;
  logic [R-1:0]     w_syn;
  logic             w_par;
  logic             w_hit;
  logic [N-1:0]     w_fixed;
  logic [N-1:0]     w_dec;
  logic [1:0]       w_dec_err;
  logic [N-1:0]     w_result;
  logic [1:0]       w_err;

  assign w_adv2     = !r_v2 || out_ready;
  assign w_adv1     = !r_v1 || w_adv2;
  assign w_out_fire = r_v2 && out_ready;

  always_comb begin
    w_enc = '0;
    for (int i = 0; i < K; i++) w_enc[data_pos(i)] = r_word[i];
    for (int j = 0; j < R; j++) begin
      for (int p = 1; p < N; p++) begin
        if ((((p >> j) & 1) == 1) && (p != (1 << j)))
          w_enc[1 << j] = w_enc[1 << j] ^ w_enc[p];
      end
    end
    w_enc[0] = ^w_enc[N-1:1];
  end

  always_comb begin
    w_syn = '0;
    for (int p = 1; p < N; p++) begin
      if (r_word[p]) w_syn = w_syn ^ R'(p);
    end
    w_par = ^r_word;

    // A syndrome naming no real position (possible when 2^R > N) is never flipped.
    w_hit   = 1'b0;
    w_fixed = r_word;
    for (int p = 1; p < N; p++) begin
      if (w_syn == R'(p)) begin
        w_hit = 1'b1;
        if (w_par) w_fixed[p] = ~r_word[p];
      end
    end

    if (w_syn == '0)
      w_dec_err = w_par ? c_err_par : c_err_clean;
    else if (w_par && w_hit)
      w_dec_err = c_err_corr;
    else
      w_dec_err = c_err_dbl;

    w_dec = '0;
    for (int i = 0; i < K; i++) w_dec[i] = w_fixed[data_pos(i)];
    w_dec[N-1] = (w_dec_err == c_err_dbl);
  end

  assign w_result = r_mode ? w_dec : w_enc;
  assign w_err    = r_mode ? w_dec_err : c_err_clean;

  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      r_v1   <= 1'b0;
      r_mode <= 1'b0;
      r_word <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_mode <= in_mode;
        r_word <= in_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      r_v2    <= 1'b0;
      r_data2 <= '0;
      r_err2  <= 2'b00;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data2 <= w_result;
        r_err2  <= w_err;
      end
    end
  end

  // Encode beats always carry err 00, so the err code alone selects the counter.
  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      r_cnt_corr <= '0;
      r_cnt_dbl  <= '0;
    end else if (clr) begin
      r_cnt_corr <= '0;
      r_cnt_dbl  <= '0;
    end else if (w_out_fire) begin
      if (((r_err2 == c_err_corr) || (r_err2 == c_err_par)) && (r_cnt_corr != c_cnt_max))
        r_cnt_corr <= r_cnt_corr + 1'b1;
      if ((r_err2 == c_err_dbl) && (r_cnt_dbl != c_cnt_max))
        r_cnt_dbl <= r_cnt_dbl + 1'b1;
    end
  end

  assign in_ready  = w_adv1;
  assign out_valid = r_v2;
  assign out_data  = r_data2;
  assign out_err   = r_err2;
  assign cnt_corr  = r_cnt_corr;
  assign cnt_dbl   = r_cnt_dbl;

endmodule

`default_nettype wire
